// File: rtl/data_mem_top.sv
// Scan-loaded DEPTH x DATA_W data memory with two independent registered read ports.
// Optional build macro DATA_MEM_OUT_REG_EN adds a second output register stage per port (read latency 2).
module data_mem_top #(
   parameter int DATA_W = 512,
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 256
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] scan_in,
   input  logic              scan_mode,
   input  logic [ADDR_W-1:0] scan_addr,
   input  logic [ADDR_W-1:0] addr_1_in,
   input  logic [ADDR_W-1:0] addr_2_in,
   input  logic              package_1_valid_in,
   input  logic              package_2_valid_in,
   output logic [DATA_W-1:0] data_1_out,
   output logic [DATA_W-1:0] data_2_out,
   output logic [ADDR_W-1:0] addr_1_out,
   output logic [ADDR_W-1:0] addr_2_out,
   output logic              package_1_valid_out,
   output logic              package_2_valid_out
);

   logic [DATA_W-1:0] mem_r [DEPTH];

   logic [DATA_W-1:0] data_1_r;
   logic [DATA_W-1:0] data_2_r;
   logic [ADDR_W-1:0] addr_1_r;
   logic [ADDR_W-1:0] addr_2_r;
   logic              valid_1_r;
   logic              valid_2_r;

   // Scan write port; memory is never cleared and reset blocks the write.
   always_ff @(posedge clk) begin
      if (reset && scan_mode) begin
         mem_r[scan_addr] <= scan_in;
      end
   end

   // Read stage: reset clears outputs, scan mode drops valid and holds data/addr.
   always_ff @(posedge clk) begin
      if (!reset) begin
         data_1_r  <= '0;
         data_2_r  <= '0;
         addr_1_r  <= '0;
         addr_2_r  <= '0;
         valid_1_r <= 1'b0;
         valid_2_r <= 1'b0;
      end else if (scan_mode) begin
         valid_1_r <= 1'b0;
         valid_2_r <= 1'b0;
      end else begin
         valid_1_r <= package_1_valid_in;
         valid_2_r <= package_2_valid_in;
         if (package_1_valid_in) begin
            data_1_r <= mem_r[addr_1_in];
            addr_1_r <= addr_1_in;
         end
         if (package_2_valid_in) begin
            data_2_r <= mem_r[addr_2_in];
            addr_2_r <= addr_2_in;
         end
      end
   end

`ifdef DATA_MEM_OUT_REG_EN
   logic [DATA_W-1:0] data_1_o_r;
   logic [DATA_W-1:0] data_2_o_r;
   logic [ADDR_W-1:0] addr_1_o_r;
   logic [ADDR_W-1:0] addr_2_o_r;
   logic              valid_1_o_r;
   logic              valid_2_o_r;

   // Extra output stage: plain copy of the read stage, so hold behaviour carries through.
   always_ff @(posedge clk) begin
      if (!reset) begin
         data_1_o_r  <= '0;
         data_2_o_r  <= '0;
         addr_1_o_r  <= '0;
         addr_2_o_r  <= '0;
         valid_1_o_r <= 1'b0;
         valid_2_o_r <= 1'b0;
      end else begin
         data_1_o_r  <= data_1_r;
         data_2_o_r  <= data_2_r;
         addr_1_o_r  <= addr_1_r;
         addr_2_o_r  <= addr_2_r;
         valid_1_o_r <= valid_1_r;
         valid_2_o_r <= valid_2_r;
      end
   end

   assign data_1_out          = data_1_o_r;
   assign data_2_out          = data_2_o_r;
   assign addr_1_out          = addr_1_o_r;
   assign addr_2_out          = addr_2_o_r;
   assign package_1_valid_out = valid_1_o_r;
   assign package_2_valid_out = valid_2_o_r;
`else
   assign data_1_out          = data_1_r;
   assign data_2_out          = data_2_r;
   assign addr_1_out          = addr_1_r;
   assign addr_2_out          = addr_2_r;
   assign package_1_valid_out = valid_1_r;
   assign package_2_valid_out = valid_2_r;
`endif

endmodule

// File: tb/tb_data_mem_top.sv
// Scoreboard bench for data_mem_top: driver pushes expected reads from a reference memory model,
// a negedge monitor pops and compares whenever a port presents valid data, and checks hold/reset otherwise.
module tb_data_mem_top;
   localparam int DW = 512;
   localparam int AW = 8;

   logic          clk;
   logic          reset;
   logic [DW-1:0] scan_in;
   logic          scan_mode;
   logic [AW-1:0] scan_addr;
   logic [AW-1:0] addr_1_in;
   logic [AW-1:0] addr_2_in;
   logic          package_1_valid_in;
   logic          package_2_valid_in;
   logic [DW-1:0] data_1_out;
   logic [DW-1:0] data_2_out;
   logic [AW-1:0] addr_1_out;
   logic [AW-1:0] addr_2_out;
   logic          package_1_valid_out;
   logic          package_2_valid_out;

   data_mem_top dut (
      .clk                 (clk),
      .reset               (reset),
      .scan_in             (scan_in),
      .scan_mode           (scan_mode),
      .scan_addr           (scan_addr),
      .addr_1_in           (addr_1_in),
      .addr_2_in           (addr_2_in),
      .package_1_valid_in  (package_1_valid_in),
      .package_2_valid_in  (package_2_valid_in),
      .data_1_out          (data_1_out),
      .data_2_out          (data_2_out),
      .addr_1_out          (addr_1_out),
      .addr_2_out          (addr_2_out),
      .package_1_valid_out (package_1_valid_out),
      .package_2_valid_out (package_2_valid_out)
   );

   typedef struct {
      logic [DW-1:0] d;
      logic [AW-1:0] a;
   } exp_t;

   exp_t          q1[$];
   exp_t          q2[$];
   logic [DW-1:0] model_mem [256];
   bit            known [256];
   logic [DW-1:0] last_d [3];
   logic [AW-1:0] last_a [3];
   logic          rst_q;
   int            checks = 0;
   int            errors = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   function automatic logic [DW-1:0] rand_word();
      logic [DW-1:0] w;
      for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
      return w;
   endfunction

   // One driven cycle: inputs change just after a rising edge and are sampled at the next one.
   task automatic issue(input logic rst_v, input logic sm, input logic [AW-1:0] sa, input logic [DW-1:0] sd,
                        input logic v1, input logic [AW-1:0] a1, input logic v2, input logic [AW-1:0] a2);
      exp_t e;
      @(posedge clk);
      #2;
      reset = rst_v; scan_mode = sm; scan_addr = sa; scan_in = sd;
      package_1_valid_in = v1; addr_1_in = a1;
      package_2_valid_in = v2; addr_2_in = a2;
      if (rst_v) begin
         if (sm) begin
            model_mem[sa] = sd;
            known[sa] = 1'b1;
         end else begin
            if (v1) begin e.d = model_mem[a1]; e.a = a1; q1.push_back(e); end
            if (v2) begin e.d = model_mem[a2]; e.a = a2; q2.push_back(e); end
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) issue(1'b1, 1'b0, 8'd0, '0, 1'b0, 8'd0, 1'b0, 8'd0);
   endtask

   task automatic rd(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
      issue(1'b1, 1'b0, 8'd0, '0, 1'b1, a1, 1'b1, a2);
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      issue(1'b1, 1'b1, a, d, 1'b0, 8'd0, 1'b0, 8'd0);
   endtask

   task automatic mon_port(input int p, input logic v, input logic [DW-1:0] d, input logic [AW-1:0] a);
      exp_t e;
      if (rst_q === 1'b0) begin
         chk($sformatf("reset_valid_%0d", p), {511'd0, v}, '0);
         chk($sformatf("reset_data_%0d", p), d, '0);
         chk($sformatf("reset_addr_%0d", p), {504'd0, a}, '0);
         last_d[p] = '0;
         last_a[p] = '0;
      end else if (v === 1'b1) begin
         if ((p == 1 && q1.size() == 0) || (p == 2 && q2.size() == 0)) begin
            chk($sformatf("spurious_valid_%0d", p), {511'd0, v}, '0);
         end else begin
            e = (p == 1) ? q1.pop_front() : q2.pop_front();
            chk($sformatf("read_data_%0d", p), d, e.d);
            chk($sformatf("read_addr_%0d", p), {504'd0, a}, {504'd0, e.a});
         end
         last_d[p] = d;
         last_a[p] = a;
      end else if (v === 1'b0) begin
         chk($sformatf("hold_data_%0d", p), d, last_d[p]);
         chk($sformatf("hold_addr_%0d", p), {504'd0, a}, {504'd0, last_a[p]});
      end else begin
         chk($sformatf("valid_known_%0d", p), {511'd0, v}, '0);
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         rst_q = reset;
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         mon_port(1, package_1_valid_out, data_1_out, addr_1_out);
         mon_port(2, package_2_valid_out, data_2_out, addr_2_out);
      end
   end

   initial begin
      logic [DW-1:0] prog [12];
      logic [AW-1:0] ra1;
      logic [AW-1:0] ra2;
      prog[0]  = 512'h002081B3; prog[1]  = 512'h000180B3; prog[2]  = 512'h0030007B;
      prog[3]  = 512'h10500073; prog[4]  = 512'h05;       prog[5]  = 512'h06;
      prog[6]  = 512'h07;       prog[7]  = 512'h08;       prog[8]  = 512'h6E;
      prog[9]  = 512'h36;       prog[10] = 512'h01;       prog[11] = 512'h02;
      for (int i = 0; i < 256; i++) begin model_mem[i] = '0; known[i] = 1'b0; end
      for (int i = 0; i < 3; i++) begin last_d[i] = '0; last_a[i] = '0; end
      rst_q = 1'b0;
      reset = 1'b0; scan_mode = 1'b0; scan_addr = '0; scan_in = '0;
      addr_1_in = '0; addr_2_in = '0; package_1_valid_in = 1'b0; package_2_valid_in = 1'b0;

      // Reset with a pending scan write and read requests: nothing lands, outputs cleared.
      issue(1'b0, 1'b1, 8'd0, rand_word(), 1'b1, 8'd0, 1'b1, 8'd1);
      issue(1'b0, 1'b0, 8'd0, '0, 1'b1, 8'd2, 1'b1, 8'd3);
      @(negedge clk);
      chk("reset_state_valid", {510'd0, package_1_valid_out, package_2_valid_out}, '0);
      chk("reset_state_data", data_1_out | data_2_out, '0);

      for (int i = 0; i < 128; i++) wr(i[AW-1:0], '0);
      for (int i = 0; i < 12; i++) wr(i[AW-1:0], prog[i]);

      rd(8'd5, 8'hA);
      rd(8'd1, 8'd9);
      rd(8'd5, 8'hB);
      idle(3);

      // Mid-stream reset after draining, then retained memory read.
      issue(1'b0, 1'b0, 8'd0, '0, 1'b1, 8'd4, 1'b1, 8'd6);
      rd(8'd3, 8'd3);
      rd(8'd0, 8'd0);

      // Read requested under scan mode is ignored; the write lands and is visible next cycle.
      issue(1'b1, 1'b1, 8'd0, 512'hDEAD_BEEF, 1'b1, 8'd0, 1'b1, 8'd0);
      rd(8'd0, 8'd0);
      wr(8'd255, rand_word());
      rd(8'd255, 8'd254 & 8'd127);
      idle(2);

      for (int n = 0; n < 400; n++) begin
         ra1 = 8'($urandom_range(0, 255));
         ra2 = 8'($urandom_range(0, 255));
         if (!known[ra1]) ra1 = ra1 & 8'd127;
         if (!known[ra2]) ra2 = ra2 & 8'd127;
         if ($urandom_range(0, 3) == 0)
            issue(1'b1, 1'b1, 8'($urandom_range(0, 255)), rand_word(),
                  1'($urandom_range(0, 1)), ra1, 1'($urandom_range(0, 1)), ra2);
         else
            issue(1'b1, 1'b0, 8'($urandom_range(0, 255)), rand_word(),
                  1'($urandom_range(0, 1)), ra1, 1'($urandom_range(0, 1)), ra2);
      end

      idle(1);
      for (int i = 0; i < 10 && (q1.size() != 0 || q2.size() != 0); i++) @(negedge clk);
      chk("drain_port1", 512'(q1.size()), '0);
      chk("drain_port2", 512'(q2.size()), '0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
